// File: rtl/au_project_mux_ctrl.sv
// au_project_mux_ctrl: Tiny Tapeout project-select mux controller emulation.
// Three raw board inputs are synchronised and (optionally) debounced. They
// then drive a saturating project address counter and a settle-delay FSM
// that produces the registered project enable `ena`.
// Build option: define AU_SEL_DEBOUNCE_EN to build the debouncers. When it
// is undefined, each debounced level is the synchroniser output directly.
module au_project_mux_ctrl #(
  parameter int PROJECT_NUMBER  = 17,
  parameter int ADDR_W          = 10,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int ENA_DELAY       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel_rst_n_raw,
  input  logic              sel_inc_raw,
  input  logic              sel_ena_raw,
  output logic              ena,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              sel_err
);

  // Input lanes: bit 0 = select-reset (active low), bit 1 = increment,
  // bit 2 = enable. These are the idle levels the lanes reset to.
  localparam logic [2:0] IDLE_LEVELS = 3'b001;
  localparam int         DLY_W       = (ENA_DELAY > 1) ? $clog2(ENA_DELAY) : 1;
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(ENA_DELAY - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_PROJECT = ADDR_W'(PROJECT_NUMBER);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    ACTIVE
  } state_t;

  logic [2:0] raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] level;

  assign raw = {sel_ena_raw, sel_inc_raw, sel_rst_n_raw};

  // Two-flop synchroniser for all three asynchronous board inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= IDLE_LEVELS;
      sync2 <= IDLE_LEVELS;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

`ifdef AU_SEL_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  for (genvar i = 0; i < 3; i++) begin : g_debounce
    logic [DB_W-1:0] cnt;
    logic            lvl;

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES samples.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
        lvl <= IDLE_LEVELS[i];
      end else if (sync2[i] == lvl) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        cnt <= '0;
        lvl <= sync2[i];
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end

    assign level[i] = lvl;
  end
`else
  assign level = sync2;

  // DEBOUNCE_CYCLES has no effect in the bypass build.
  if (DEBOUNCE_CYCLES < 1) begin : g_debounce_cycles_unused
  end
`endif

  logic rst_n_db;
  logic inc_db;
  logic ena_db;
  logic inc_prev;
  logic inc_rise;
  logic qual;

  assign rst_n_db = level[0];
  assign inc_db   = level[1];
  assign ena_db   = level[2];
  assign inc_rise = inc_db & ~inc_prev;

  // Address counter: select-reset clears, increment saturates, and an
  // increment while enabled is refused and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      inc_prev <= 1'b0;
      cur_addr <= '0;
      sel_err  <= 1'b0;
    end else begin
      inc_prev <= inc_db;
      if (!rst_n_db) begin
        cur_addr <= '0;
        sel_err  <= 1'b0;
      end else if (inc_rise && !ena_db) begin
        if (cur_addr != ADDR_MAX) begin
          cur_addr <= cur_addr + ADDR_W'(1);
        end
      end else if (inc_rise) begin
        sel_err <= 1'b1;
      end
    end
  end

  assign qual = rst_n_db & ena_db & (cur_addr == ADDR_PROJECT);

  state_t           state;
  state_t           state_next;
  logic [DLY_W-1:0] dly;
  logic [DLY_W-1:0] dly_next;

  // FSM state, settle counter and the registered enable output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dly   <= '0;
      ena   <= 1'b0;
    end else begin
      state <= state_next;
      dly   <= dly_next;
      ena   <= (state_next == ACTIVE);
    end
  end

  // Next-state logic: qualification must hold through the whole settle delay.
  always_comb begin
    state_next = state;
    dly_next   = dly;
    case (state)
      IDLE: begin
        if (qual) begin
          state_next = ARM;
          dly_next   = DLY_LOAD;
        end
      end
      ARM: begin
        if (!qual) begin
          state_next = IDLE;
        end else if (dly == '0) begin
          state_next = ACTIVE;
        end else begin
          dly_next = dly - DLY_W'(1);
        end
      end
      ACTIVE: begin
        if (!qual) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_au_project_mux_ctrl.sv
// tb_au_project_mux_ctrl: directed scenarios plus randomized input traffic,
// checked every cycle against a behavioural model of the select controller.
// Works with AU_SEL_DEBOUNCE_EN defined or undefined.
module tb_au_project_mux_ctrl;

  localparam int PN = 17;
  localparam int AW = 10;
  localparam int DB = 4;
  localparam int ED = 3;
`ifdef AU_SEL_DEBOUNCE_EN
  localparam bit DB_ON = 1'b1;
`else
  localparam bit DB_ON = 1'b0;
`endif
  localparam int IN_LAT = DB_ON ? 2 + DB : 2;
  localparam logic [AW-1:0] MAX_ADDR = '1;

  logic          clk = 1'b0;
  logic          rst;
  logic          rn;
  logic          inc;
  logic          en;
  logic          ena;
  logic [AW-1:0] cur_addr;
  logic          sel_err;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  au_project_mux_ctrl #(
    .PROJECT_NUMBER (PN),
    .ADDR_W         (AW),
    .DEBOUNCE_CYCLES(DB),
    .ENA_DELAY      (ED)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sel_rst_n_raw(rn),
    .sel_inc_raw  (inc),
    .sel_ena_raw  (en),
    .ena          (ena),
    .cur_addr     (cur_addr),
    .sel_err      (sel_err)
  );

  // Behavioural model. Debounced level flips once the last DB synchronised
  // samples all disagree with it; ena is high exactly when qualification has
  // held for the last ED+1 clock edges.
  bit            m_s1 [3];
  bit            m_s2 [3];
  bit            m_db [3];
  bit            m_hist [3][DB];
  bit            m_inc_prev;
  bit            m_err;
  bit            m_ena;
  logic [AW-1:0] m_addr;
  int            m_run;
  bit            raw_now [3];
  bit            m_q;
  bit            m_rise;
  bit            all_diff;

  always @(posedge clk) begin
    raw_now[0] = rn;
    raw_now[1] = inc;
    raw_now[2] = en;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_s1[i] = (i == 0);
        m_s2[i] = (i == 0);
        m_db[i] = (i == 0);
        for (int k = 0; k < DB; k++) m_hist[i][k] = (i == 0);
      end
      m_inc_prev = 1'b0;
      m_err      = 1'b0;
      m_ena      = 1'b0;
      m_addr     = '0;
      m_run      = 0;
    end else begin
      m_q    = m_db[0] && m_db[2] && (m_addr == AW'(PN));
      m_rise = m_db[1] && !m_inc_prev;
      if (!m_db[0]) begin
        m_addr = '0;
        m_err  = 1'b0;
      end else if (m_rise && !m_db[2]) begin
        if (m_addr != MAX_ADDR) m_addr = m_addr + 1'b1;
      end else if (m_rise) begin
        m_err = 1'b1;
      end
      m_run = m_q ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
      m_ena = (m_run >= ED + 1);
      m_inc_prev = m_db[1];
      for (int i = 0; i < 3; i++) begin
        if (DB_ON) begin
          for (int k = DB - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
          m_hist[i][0] = m_s2[i];
          all_diff = 1'b1;
          for (int k = 0; k < DB; k++) if (m_hist[i][k] == m_db[i]) all_diff = 1'b0;
          if (all_diff) m_db[i] = !m_db[i];
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = raw_now[i];
        if (!DB_ON) m_db[i] = m_s2[i];
      end
    end
  end

  // Single checking task: counts every comparison and reports mismatches.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  // Continuous comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      checkOutput("model_ena", ena, m_ena);
      checkOutput("model_cur_addr", cur_addr, m_addr);
      checkOutput("model_sel_err", sel_err, m_err);
    end
  end

  // Drive raw inputs at a falling edge and hold them for n cycles.
  task automatic applyStimulus(input bit rn_v, input bit inc_v, input bit en_v, input int n);
    rn  = rn_v;
    inc = inc_v;
    en  = en_v;
    repeat (n) @(negedge clk);
  endtask

  task automatic incPulses(input int count, input int hi, input int lo);
    for (int p = 0; p < count; p++) begin
      applyStimulus(rn, 1'b1, en, hi);
      applyStimulus(rn, 1'b0, en, lo);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 3);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Count clock edges until ena reaches the wanted level, bounded by limit.
  task automatic measureEna(input bit want, input int limit, output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (ena != want && cycles < limit);
    if (ena != want) checkOutput("ena_wait_timeout", ena, want);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    bit ena_seen;

    rst = 1'b1;
    rn  = 1'b1;
    inc = 1'b0;
    en  = 1'b0;
    repeat (2) @(negedge clk);
    doReset();
    chk_on = 1'b1;

    checkOutput("reset_ena", ena, 0);
    checkOutput("reset_cur_addr", cur_addr, 0);
    checkOutput("reset_sel_err", sel_err, 0);

    // Scenario 1: select project 17 and enable it.
    incPulses(17, 8, 8);
    checkOutput("s1_cur_addr", cur_addr, 17);
    en = 1'b1;
    measureEna(1'b1, 60, lat);
    checkOutput("s1_ena_latency", lat, IN_LAT + ED + 1);
    checkOutput("s1_sel_err", sel_err, 0);

    // Scenario 3: increments while enabled are refused and flagged.
    applyStimulus(1'b1, 1'b1, 1'b1, 3);
    applyStimulus(1'b1, 1'b0, 1'b1, 12);
    checkOutput("s3_short_cur_addr", cur_addr, 17);
    checkOutput("s3_short_sel_err", sel_err, DB_ON ? 0 : 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 6);
    applyStimulus(1'b1, 1'b0, 1'b1, 12);
    checkOutput("s3_long_cur_addr", cur_addr, 17);
    checkOutput("s3_long_sel_err", sel_err, 1);
    checkOutput("s3_long_ena", ena, 1);

    // Scenario 4: select-reset while enabled.
    rn = 1'b0;
    measureEna(1'b0, 60, lat);
    checkOutput("s4_ena_fall_latency", lat, IN_LAT + 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 3);
    applyStimulus(1'b1, 1'b0, 1'b1, 12);
    checkOutput("s4_cur_addr", cur_addr, 0);
    checkOutput("s4_sel_err", sel_err, 0);
    checkOutput("s4_ena", ena, 0);

    // Scenario 2: wrong project address never enables.
    doReset();
    incPulses(16, 8, 8);
    applyStimulus(1'b1, 1'b0, 1'b1, 100);
    checkOutput("s2_cur_addr", cur_addr, 16);
    checkOutput("s2_ena", ena, 0);

    // Scenario 5a: qualification withdrawn while arming.
    doReset();
    incPulses(17, 8, 8);
    ena_seen = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 2);
    rn = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (c == 6) rn = 1'b1;
      @(negedge clk);
      ena_seen = ena_seen | ena;
    end
    checkOutput("s5_no_ena_pulse", ena_seen, 0);
    checkOutput("s5_abort_cur_addr", cur_addr, 0);

    // Scenario 5b: address saturates at the top.
    doReset();
    incPulses((1 << AW) + 5, 6, 6);
    applyStimulus(1'b1, 1'b0, 1'b0, 10);
    checkOutput("s5_saturate", cur_addr, int'(MAX_ADDR));

    // Scenario 6: synchronous reset while active.
    doReset();
    incPulses(17, 8, 8);
    en = 1'b1;
    measureEna(1'b1, 60, lat);
    checkOutput("s6_ena_latency", lat, IN_LAT + ED + 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("s6_rst_ena", ena, 0);
    checkOutput("s6_rst_cur_addr", cur_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 10);

    // Randomized traffic around the project address.
    doReset();
    incPulses(17, 8, 8);
    for (int it = 0; it < 400; it++) begin
      applyStimulus(($urandom_range(0, 11) != 0), $urandom_range(0, 1),
                    $urandom_range(0, 1), $urandom_range(1, 10));
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 20);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
